// File: rtl/bram_rd_seq.sv
// Burst read sequencer: sequential single-word reads from the BRAM controller, streamed out on valid/ready.
// Latency: start -> first ctrl_rden 1 cycle, first out_val 3 cycles; one word per cycle sustained.
// Backpressure: reads are issued only while FIFO occupancy plus the in-flight read leaves room, so out_rdy low never drops data.

// Return-data FIFO: single clock, head word visible combinationally, no overflow/underflow protection.
module bram_rd_seq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_vld,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_vld) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_vld, pop_vld})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage cleared on reset so the head word reads as zero when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module bram_rd_seq #(
    parameter int DAT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ADDR_STEP  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [DAT_WIDTH-1:0]  out_dat,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic                  ctrl_rden,
    output logic                  ctrl_wren,
    output logic [DAT_WIDTH-1:0]  ctrl_idat,
    input  logic [DAT_WIDTH-1:0]  ctrl_odat,
    input  logic                  ctrl_oval
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  inflight_q;
    logic                  done_q, done_d;

    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         credit_sum;
    logic                  fifo_push;
    logic                  fifo_pop;

    // Credit uses registered occupancy only: a pop this cycle is not counted as free space.
    assign credit_sum = fifo_count + CW'(inflight_q);
    assign ctrl_rden  = (state_q == S_RUN) && (remaining_q != '0) &&
                        (credit_sum < CW'(FIFO_DEPTH));
    assign ctrl_addr  = addr_q;
    assign ctrl_wren  = 1'b0;
    assign ctrl_idat  = '0;

    // Returned words are only meaningful inside a burst; stale ones after reset are dropped.
    assign fifo_push  = ctrl_oval && (state_q != S_IDLE);
    assign out_val    = (fifo_count != '0);
    assign fifo_pop   = out_val && out_rdy;

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

    bram_rd_seq_fifo #(
        .W     (DAT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (fifo_push),
        .push_dat (ctrl_odat),
        .pop_vld  (fifo_pop),
        .head_dat (out_dat),
        .count    (fifo_count)
    );

    // Sequencer next-state: capture request, issue reads, then finish once the last word leaves.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = len;
                    if (len != '0) begin
                        state_d = S_RUN;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (ctrl_rden) begin
                    addr_d      = addr_q + ADDR_WIDTH'(ADDR_STEP);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Finish in the cycle of the final handshake so done lands right after it.
                if (!inflight_q &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= ctrl_rden;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_bram_rd_seq.sv
// Directed bench for bram_rd_seq with a one-cycle-latency BRAM model that returns the address as data.
module tb_bram_rd_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] out_dat;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] ctrl_addr;
    logic        ctrl_rden;
    logic        ctrl_wren;
    logic [31:0] ctrl_idat;
    logic [31:0] ctrl_odat;
    logic        ctrl_oval;

    int errors = 0;
    int checks = 0;

    bram_rd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .out_dat   (out_dat),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .ctrl_addr (ctrl_addr),
        .ctrl_rden (ctrl_rden),
        .ctrl_wren (ctrl_wren),
        .ctrl_idat (ctrl_idat),
        .ctrl_odat (ctrl_odat),
        .ctrl_oval (ctrl_oval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM controller model: data valid one cycle after rden, data equals address.
    always_ff @(posedge clk) begin
        ctrl_oval <= ctrl_rden;
        ctrl_odat <= ctrl_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one burst to completion; checks word order/count, read count and done/busy at the end.
    // stall: out_rdy held low for cycles 1..stall; rnd: random out_rdy plus spurious starts while busy.
    task automatic run_burst(input logic [31:0] base, input int n, input bit rnd,
                             input int stall, output int rd_before_stall);
        int  idx;
        int  rd_total;
        bit  done_seen;
        bit  busy_at_done;
        idx = 0; rd_total = 0; done_seen = 0; busy_at_done = 1; rd_before_stall = 0;
        base_addr = base;
        len       = 16'(n);
        start     = 1'b1;
        step();
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (rnd) begin
                out_rdy = 1'($urandom_range(0, 1));
                if (busy && ($urandom_range(0, 3) == 0)) begin
                    start     = 1'b1;
                    base_addr = 32'hDEAD_0000;
                    len       = 16'd5;
                end else begin
                    start = 1'b0;
                end
            end else begin
                start   = 1'b0;
                out_rdy = (cyc > stall);
            end
            if (ctrl_rden) begin
                rd_total++;
                if (cyc <= stall) rd_before_stall++;
            end
            if (out_val && out_rdy) begin
                chk("word", out_dat, base + 32'(idx) * 32'd4);
                idx++;
            end
            if (done) begin
                done_seen    = 1;
                busy_at_done = busy;
                break;
            end
            step();
        end
        start = 1'b0;
        chk("word_count", 32'(idx), 32'(n));
        chk("read_count", 32'(rd_total), 32'(n));
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        chk("busy_at_done", {31'd0, busy_at_done}, 32'd0);
        step();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int rd_stall;
        rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_rdy = 1'b0;
        step();
        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_val", {31'd0, out_val}, 32'd0);
        chk("rst_out_dat", out_dat, 32'd0);
        chk("rst_rden", {31'd0, ctrl_rden}, 32'd0);
        chk("rst_addr", ctrl_addr, 32'd0);
        chk("rst_wren", {31'd0, ctrl_wren}, 32'd0);
        chk("rst_idat", ctrl_idat, 32'd0);
        rst = 1'b1;
        step();

        // Directed cycle-accurate burst: base 0x100, len 4, out_rdy high
        out_rdy = 1'b1; base_addr = 32'h100; len = 16'd4; start = 1'b1;
        step(); start = 1'b0;                         // cycle 1
        chk("c1_busy", {31'd0, busy}, 32'd1);
        chk("c1_rden", {31'd0, ctrl_rden}, 32'd1);
        chk("c1_addr", ctrl_addr, 32'h100);
        chk("c1_out_val", {31'd0, out_val}, 32'd0);
        step();                                       // cycle 2
        chk("c2_rden", {31'd0, ctrl_rden}, 32'd1);
        chk("c2_addr", ctrl_addr, 32'h104);
        chk("c2_out_val", {31'd0, out_val}, 32'd0);
        step();                                       // cycle 3
        chk("c3_addr", ctrl_addr, 32'h108);
        chk("c3_out_val", {31'd0, out_val}, 32'd1);
        chk("c3_out_dat", out_dat, 32'h100);
        step();                                       // cycle 4
        chk("c4_rden", {31'd0, ctrl_rden}, 32'd1);
        chk("c4_addr", ctrl_addr, 32'h10C);
        chk("c4_out_dat", out_dat, 32'h104);
        step();                                       // cycle 5
        chk("c5_rden", {31'd0, ctrl_rden}, 32'd0);
        chk("c5_out_dat", out_dat, 32'h108);
        step();                                       // cycle 6
        chk("c6_out_dat", out_dat, 32'h10C);
        chk("c6_done", {31'd0, done}, 32'd0);
        step();                                       // cycle 7
        chk("c7_done", {31'd0, done}, 32'd1);
        chk("c7_busy", {31'd0, busy}, 32'd0);
        chk("c7_out_val", {31'd0, out_val}, 32'd0);
        // New start accepted in the done cycle (len 0 -> done again next cycle)
        len = 16'd0; base_addr = 32'h40; start = 1'b1;
        step(); start = 1'b0;
        chk("restart_done", {31'd0, done}, 32'd1);
        chk("restart_busy", {31'd0, busy}, 32'd0);
        step();

        // len = 0: no reads, busy stays low, done on cycle 1 only
        len = 16'd0; base_addr = 32'h200; start = 1'b1;
        step(); start = 1'b0;
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_rden", {31'd0, ctrl_rden}, 32'd0);
        step();
        chk("len0_done_clr", {31'd0, done}, 32'd0);
        chk("len0_rden2", {31'd0, ctrl_rden}, 32'd0);

        // len 16 with 20 stalled cycles: exactly FIFO_DEPTH reads before the stall lifts
        run_burst(32'h2000, 16, 1'b0, 20, rd_stall);
        chk("stall_reads", 32'(rd_stall), 32'd4);

        // Address wrap
        run_burst(32'hFFFF_FFF8, 4, 1'b0, 0, rd_stall);

        // Random backpressure with ignored starts while busy
        run_burst(32'h8000, 100, 1'b1, 0, rd_stall);

        // Reset mid-burst at cycle 5 of a len-10 burst, with out_rdy low
        out_rdy = 1'b0; base_addr = 32'h300; len = 16'd10; start = 1'b1;
        step(); start = 1'b0;
        repeat (4) step();                            // now cycle 5
        chk("pre_rst_out_val", {31'd0, out_val}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_out_val", {31'd0, out_val}, 32'd0);
        chk("mid_rst_out_dat", out_dat, 32'd0);
        chk("mid_rst_rden", {31'd0, ctrl_rden}, 32'd0);
        chk("mid_rst_addr", ctrl_addr, 32'd0);
        #1;
        rst = 1'b1;                                   // released while a stale oval is pending
        step();
        chk("stale_oval_dropped", {31'd0, out_val}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        run_burst(32'h500, 3, 1'b0, 0, rd_stall);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bram_rd_seq.md
# bram_rd_seq

Burst read sequencer that drives the user side of the team's BRAM controller (addr/wren/idat/rden in, odat/oval back one cycle later). Given a base address and word count, it issues sequential single-word reads and streams the returned words out on a valid/ready interface. A small FIFO absorbs the controller's fixed one-cycle read latency so downstream backpressure never loses data. It sits between a BRAM controller instance and the feature-map/weight consumers in the accelerator datapath.

## Interface
- DAT_WIDTH, 32, data word width (matches the controller)
- ADDR_WIDTH, 32, address width (matches the controller)
- LEN_WIDTH, 16, width of the burst length field
- ADDR_STEP, 4, address increment per word (byte-addressed BRAM)
- FIFO_DEPTH, 4, return-data FIFO entries; power of two, at least 2
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, captured with start
- len  in  LEN_WIDTH  number of words, captured with start
- busy  out  1  high from the cycle after an accepted start until completion
- done  out  1  one-cycle completion pulse
- out_dat  out  DAT_WIDTH  FIFO head word
- out_val  out  1  FIFO not empty
- out_rdy  in  1  consumer accepts out_dat when out_val && out_rdy
- ctrl_addr  out  ADDR_WIDTH  to controller addr
- ctrl_rden  out  1  to controller rden
- ctrl_wren  out  1  tied 0
- ctrl_idat  out  DAT_WIDTH  tied 0
- ctrl_odat  in  DAT_WIDTH  from controller odat
- ctrl_oval  in  1  from controller oval; valid exactly one cycle after ctrl_rden

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 captures base_addr into addr register and len into remaining counter; next state RUN if len!=0, else stay IDLE and pulse done the next cycle (no reads issued). start while busy is ignored.
- RUN: ctrl_rden = (remaining!=0) && (fifo_count + inflight < FIFO_DEPTH), combinational from registered values only (a pop in the same cycle gives no credit). inflight = ctrl_rden of previous cycle. ctrl_addr = addr register. Each issue: addr += ADDR_STEP (wraps modulo 2^ADDR_WIDTH), remaining -= 1. When remaining reaches 0, go to DRAIN.
- ctrl_oval=1 in RUN/DRAIN pushes ctrl_odat into the FIFO; the credit rule guarantees no overflow. ctrl_oval in IDLE is dropped.
- Simultaneous push and pop: count unchanged, both happen.
- DRAIN: wait for inflight=0 and FIFO empty, then return to IDLE with done=1 for one cycle.
- Words are output in address order, exactly len words, none duplicated or dropped under any out_rdy pattern.

## Timing
- Reset values: busy=0, done=0, out_val=0, out_dat=0, ctrl_rden=0, ctrl_addr=0; FIFO, counters and inflight cleared; state IDLE.
- Reset asserted mid-burst aborts immediately; a pending ctrl_oval after reset release is ignored.
- start at edge T0 -> RUN in cycle 1, first ctrl_rden in cycle 1, ctrl_oval cycle 2, out_val cycle 3.
- With out_rdy held 1: one word per cycle sustained; last word out at cycle len+2.
- done: the cycle after the final out handshake (or cycle 1 for len=0); busy=0 in that cycle; a new start is accepted in the done cycle.
- out_dat stable while out_val && !out_rdy.

## Test plan
- base_addr=0x100, len=4, out_rdy=1 -> ctrl_addr 0x100,0x104,0x108,0x10C on cycles 1-4; out words in order on cycles 3-6; done on cycle 7.
- len=0 -> no ctrl_rden, busy stays 0, done pulses on cycle 1.
- len=16, out_rdy=0 for 20 cycles then 1 -> exactly FIFO_DEPTH reads issued before stall, no overflow, all 16 words delivered in order.
- base_addr=0xFFFFFFF8, len=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Random out_rdy toggling, len=100, BRAM model returning addr as data -> scoreboard matches 100 words, start pulses during busy ignored.
- Reset asserted at cycle 5 of a len=10 burst -> all outputs zero immediately; new start after release runs a clean burst.
